// File: rtl/charram_ctl.sv
// -----------------------------------------------------------------------------
// charram_ctl -- access controller for the 512 x 8 character data RAM.
//
// The RAM's single read port is shared between the video fetch path, which
// always wins, and a host read requester that is served only in cycles the
// video path leaves idle. The RAM's write port is driven by the host write
// requester, or by the clear sequencer while it runs.
//
// Optional feature: define CHARRAM_CLEAR_EN to include the clear sequencer,
// which fills the whole RAM with CLEAR_VALUE, one address per cycle, after
// every reset. Without it, busy is tied 0 and RAM contents are undefined
// after reset.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   vid_rd_req/addr               video read strobe + address, one per address
//   vid_rd_data/valid             video read data, one-cycle valid pulse
//   host_rd_req/addr              host read request, held until ack
//   host_rd_data/ack              registered host read data, one-cycle ack
//   host_wr_req/addr/data         host write request, held until ack
//   host_wr_ack                   one-cycle pulse, write committed to RAM
//   busy                          clear sequencer active
//   ram_rd/ram_rd_addr            RAM read enable + address
//   ram_rd_data                   RAM registered read data
//   ram_wr/ram_wr_addr/ram_wr_data RAM write enable, address, data
// -----------------------------------------------------------------------------
module charram_ctl #(
    parameter int                ADDR_W      = 9,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_rd_req,
    input  logic [ADDR_W-1:0] vid_rd_addr,
    output logic [DATA_W-1:0] vid_rd_data,
    output logic              vid_rd_valid,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              host_rd_ack,
    input  logic              host_wr_req,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ack,
    output logic              busy,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data
);

    // Host read states.
    localparam logic [1:0] RD_IDLE     = 2'd0;
    localparam logic [1:0] RD_INFLIGHT = 2'd1;
    localparam logic [1:0] RD_ACK      = 2'd2;

    logic [1:0]        rd_state_q, rd_state_d;
    logic [DATA_W-1:0] host_rd_data_q, host_rd_data_d;
    logic              vid_rd_valid_q, vid_rd_valid_d;
    logic              host_wr_ack_q, host_wr_ack_d;

    logic              host_rd_inflight;
    logic              host_rd_issue;
    logic              host_wr_issue;
    logic              clr_wr;
    logic [ADDR_W-1:0] clr_addr;

    // ---------------------------------------------------------------- read port
    assign host_rd_inflight = (rd_state_q == RD_INFLIGHT);
    assign host_rd_ack      = (rd_state_q == RD_ACK);

    // Video has fixed priority; the host only gets cycles video leaves idle,
    // and never re-issues while its previous read is in flight or being acked.
    assign host_rd_issue = host_rd_req & ~vid_rd_req & ~host_rd_inflight & ~host_rd_ack;
    assign ram_rd        = vid_rd_req | host_rd_issue;
    assign ram_rd_addr   = vid_rd_req ? vid_rd_addr : host_rd_addr;

    // The RAM read register is not reset, so the pass-through is qualified by
    // valid to keep vid_rd_data at 0 outside of a valid pulse (and in reset).
    assign vid_rd_data  = vid_rd_valid_q ? ram_rd_data : {DATA_W{1'b0}};
    assign vid_rd_valid = vid_rd_valid_q;
    assign host_rd_data = host_rd_data_q;

    // NOTE: every always_comb output gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    always_comb begin
        rd_state_d     = rd_state_q;
        host_rd_data_d = host_rd_data_q;
        vid_rd_valid_d = vid_rd_req;
        case (rd_state_q)
            RD_IDLE: begin
                if (host_rd_issue) begin
                    rd_state_d = RD_INFLIGHT;
                end
            end
            RD_INFLIGHT: begin
                // RAM data for the host address is on ram_rd_data this cycle.
                host_rd_data_d = ram_rd_data;
                rd_state_d     = RD_ACK;
            end
            RD_ACK:  rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // --------------------------------------------------------------- write port
    assign host_wr_issue = host_wr_req & ~host_wr_ack_q & ~busy;
    assign host_wr_ack_d = host_wr_issue;
    assign host_wr_ack   = host_wr_ack_q;

    assign ram_wr      = clr_wr | host_wr_issue;
    assign ram_wr_addr = clr_wr ? clr_addr : host_wr_addr;
    assign ram_wr_data = clr_wr ? CLEAR_VALUE : host_wr_data;

`ifdef CHARRAM_CLEAR_EN
    // Clear sequencer states.
    localparam logic [0:0] CLR_RUN   = 1'b0;
    localparam logic [0:0] CLR_CLEAR = 1'b1;

    logic [0:0]        clr_state_q, clr_state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        clr_state_d = clr_state_q;
        clr_cnt_d   = clr_cnt_q;
        if (clr_state_q == CLR_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                clr_state_d = CLR_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state_q <= CLR_CLEAR;
            clr_cnt_q   <= {ADDR_W{1'b0}};
        end else begin
            clr_state_q <= clr_state_d;
            clr_cnt_q   <= clr_cnt_d;
        end
    end

    assign busy     = (clr_state_q == CLR_CLEAR);
    // Hold the RAM write port quiet while reset is asserted; the sequencer
    // starts writing address 0 at the first edge after release.
    assign clr_wr   = busy & rst_n;
    assign clr_addr = clr_cnt_q;
`else
    assign busy     = 1'b0;
    assign clr_wr   = 1'b0;
    assign clr_addr = {ADDR_W{1'b0}};
`endif

    // ---------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q     <= RD_IDLE;
            host_rd_data_q <= {DATA_W{1'b0}};
            vid_rd_valid_q <= 1'b0;
            host_wr_ack_q  <= 1'b0;
        end else begin
            rd_state_q     <= rd_state_d;
            host_rd_data_q <= host_rd_data_d;
            vid_rd_valid_q <= vid_rd_valid_d;
            host_wr_ack_q  <= host_wr_ack_d;
        end
    end

endmodule
